ex_muldiv_unit: RTL and testbench

- Parametrised multi-cycle multiply/divide unit that sits beside the ALU in the EX stage.
- Replaces the separate fixed-32-bit mul and div instances with one shared shift-add/shift-subtract datapath.
- Supports signed and unsigned MULT/DIV, a start/ready handshake, annul, and divide-by-zero detection.
- Drives the EX stall request while it is computing; results go to HI/LO via the MEM bus.

---
 rtl/ex_muldiv_unit_if.sv | 27 ++
 rtl/ex_muldiv_unit.sv | 156 +++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/ex_muldiv_unit_if.sv
// Handshake and result bus between the EX stage (master) and the shared multiply/divide unit
// (slave).
interface ex_muldiv_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic             annul;
    logic [1:0]       op;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             stallreq;
    logic             busy;
    logic             ready;
    logic             div_by_zero;
    logic [WIDTH-1:0] result_hi;
    logic [WIDTH-1:0] result_lo;

    modport master (
        output start, annul, op, opa, opb,
        input  stallreq, busy, ready, div_by_zero, result_hi, result_lo
    );

    modport slave (
        input  start, annul, op, opa, opb,
        output stallreq, busy, ready, div_by_zero, result_hi, result_lo
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Multi-cycle signed/unsigned multiply (shift-add) and divide (restoring) unit.
// One shared 2*WIDTH accumulator; results are sign-corrected and registered on entry to DONE.
module ex_muldiv_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input logic             clk,
    input logic             rst,
    ex_muldiv_unit_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

    state_e             r_state;
    state_e             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_m;
    logic [2*WIDTH-1:0] r_acc;
    logic               r_neg_lo;
    logic               r_neg_hi;
    logic               r_dbz;
    logic [WIDTH-1:0]   r_res_hi;
    logic [WIDTH-1:0]   r_res_lo;

    logic               w_accept;
    logic               w_is_signed;
    logic               w_last;
    logic               w_busy;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_div_shift;
    logic [WIDTH:0]     w_div_diff;
    logic [WIDTH-1:0]   w_div_rem;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [2*WIDTH-1:0] w_div_next;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    assign w_accept    = bus.start & ~bus.annul;
    assign w_is_signed = ~bus.op[0];
    assign w_abs_a     = (w_is_signed & bus.opa[WIDTH-1]) ? -bus.opa : bus.opa;
    assign w_abs_b     = (w_is_signed & bus.opb[WIDTH-1]) ? -bus.opb : bus.opb;
    assign w_last      = (r_cnt == CNT_W'(WIDTH - 1));

    // MUL: acc = {partial product, remaining multiplier bits}; add and shift right each cycle.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_m} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // DIV: acc = {remainder, dividend/quotient}; quotient bits shift in from the bottom.
    assign w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_m};
    assign w_div_rem   = w_div_diff[WIDTH] ? w_div_shift[WIDTH-1:0] : w_div_diff[WIDTH-1:0];
    assign w_div_next  = {w_div_rem, r_acc[WIDTH-2:0], ~w_div_diff[WIDTH]};

    assign w_prod = r_neg_lo ? -w_mul_next : w_mul_next;
    assign w_quo  = r_neg_lo ? -w_div_next[WIDTH-1:0] : w_div_next[WIDTH-1:0];
    assign w_rem  = r_neg_hi ? -w_div_next[2*WIDTH-1:WIDTH] : w_div_next[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (bus.annul) begin
            w_state_next = StIdle;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (bus.start) begin
                        if (!bus.op[1]) begin
                            w_state_next = StMul;
                        end else if (bus.opb == '0) begin
                            w_state_next = StDone;
                        end else begin
                            w_state_next = StDiv;
                        end
                    end
                end
                StMul, StDiv: begin
                    if (w_last) begin
                        w_state_next = StDone;
                    end
                end
                StDone:  w_state_next = StIdle;
                default: w_state_next = StIdle;
            endcase
        end
    end

    always_comb begin
        w_busy          = (r_state == StMul) || (r_state == StDiv);
        bus.busy        = w_busy;
        bus.ready       = (r_state == StDone);
        bus.stallreq    = ((r_state == StIdle) & w_accept) | w_busy;
        bus.div_by_zero = r_dbz;
        bus.result_hi   = r_res_hi;
        bus.result_lo   = r_res_lo;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_m      <= '0;
            r_acc    <= '0;
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
            r_dbz    <= 1'b0;
            r_res_hi <= '0;
            r_res_lo <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_cnt    <= '0;
                        r_neg_lo <= w_is_signed & (bus.opa[WIDTH-1] ^ bus.opb[WIDTH-1]);
                        r_neg_hi <= w_is_signed & bus.opa[WIDTH-1];
                        if (bus.op[1]) begin
                            r_m   <= w_abs_b;
                            r_acc <= {{WIDTH{1'b0}}, w_abs_a};
                        end else begin
                            r_m   <= w_abs_a;
                            r_acc <= {{WIDTH{1'b0}}, w_abs_b};
                        end
                        // Divide-by-zero completes straight away with fixed results.
                        if (bus.op[1] && (bus.opb == '0)) begin
                            r_dbz    <= 1'b1;
                            r_res_hi <= bus.opa;
                            r_res_lo <= '1;
                        end
                    end
                end
                StMul, StDiv: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    r_acc <= (r_state == StDiv) ? w_div_next : w_mul_next;
                    if (w_state_next == StDone) begin
                        r_dbz <= 1'b0;
                        if (r_state == StDiv) begin
                            r_res_hi <= w_rem;
                            r_res_lo <= w_quo;
                        end else begin
                            r_res_hi <= w_prod[2*WIDTH-1:WIDTH];
                            r_res_lo <= w_prod[WIDTH-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: expected results are queued at start and checked at ready.
module tb_ex_muldiv_unit;
    localparam int unsigned W = 32;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
        logic [7:0]   lat;
    } exp_t;

    logic clk;
    logic rst;
    exp_t sb[$];
    exp_t last;
    int   n_cmp;
    int   n_bad;
    int   n_ready;
    int   exp_ready;

    ex_muldiv_unit_if #(.WIDTH(W)) bus ();

    ex_muldiv_unit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.ready === 1'b1) n_ready++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: observed no finish, required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b);
        exp_t        e;
        longint      sa;
        longint      sb_;
        logic [63:0] t;
        logic [63:0] u;
        sa    = longint'($signed(a));
        sb_   = longint'($signed(b));
        e.dbz = 1'b0;
        e.lat = 8'(W + 1);
        case (op)
            2'b00: begin
                t    = sa * sb_;
                e.hi = t[63:32];
                e.lo = t[31:0];
            end
            2'b01: begin
                t    = {32'b0, a} * {32'b0, b};
                e.hi = t[63:32];
                e.lo = t[31:0];
            end
            default: begin
                if (b == '0) begin
                    e.dbz = 1'b1;
                    e.lat = 8'd1;
                    e.hi  = a;
                    e.lo  = '1;
                end else if (op == 2'b10) begin
                    t    = sa / sb_;
                    u    = sa % sb_;
                    e.lo = t[31:0];
                    e.hi = u[31:0];
                end else begin
                    e.lo = a / b;
                    e.hi = a % b;
                end
            end
        endcase
        return e;
    endfunction

    // Start one operation, optionally hammer start/operands while busy, then check at ready.
    task automatic do_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit poke);
        exp_t e;
        int   lat;
        bit   stall_ok;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.opa   = a;
        bus.opb   = b;
        #1;
        check("stall_start", bus.stallreq, 1);
        sb.push_back(model(op, a, b));
        @(negedge clk);
        bus.start = poke;
        bus.op    = ~op;
        bus.opa   = ~a;
        bus.opb   = ~b;
        lat       = 1;
        stall_ok  = 1'b1;
        #1;
        while (bus.ready !== 1'b1 && lat < 60) begin
            if (bus.stallreq !== 1'b1) stall_ok = 1'b0;
            @(negedge clk);
            lat++;
            #1;
        end
        bus.start = 1'b0;
        e = sb.pop_front();
        check("ready_seen", bus.ready, 1);
        check("latency", 64'(lat), 64'(e.lat));
        check("stall_busy", stall_ok, 1);
        check("stall_done", bus.stallreq, 0);
        check("result_hi", bus.result_hi, e.hi);
        check("result_lo", bus.result_lo, e.lo);
        check("div_by_zero", bus.div_by_zero, e.dbz);
        exp_ready++;
        last = e;
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        n_ready   = 0;
        exp_ready = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.annul = 1'b0;
        bus.op    = 2'b00;
        bus.opa   = '0;
        bus.opb   = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_stall", bus.stallreq, 0);
        check("rst_ready", bus.ready, 0);
        check("rst_dbz", bus.div_by_zero, 0);
        check("rst_hi", bus.result_hi, 0);
        check("rst_lo", bus.result_lo, 0);
        rst = 1'b0;

        do_op(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0);
        do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
        do_op(2'b11, 32'd100, 32'd7, 1'b0);
        do_op(2'b11, 32'h0000_1234, 32'd0, 1'b0);
        do_op(2'b01, 32'd2, 32'd3, 1'b1);
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        do_op(2'b10, 32'd7, 32'hFFFF_FFFE, 1'b0);
        do_op(2'b00, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 1'b0);
        do_op(2'b10, 32'h8765_4321, 32'd0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            do_op(2'($urandom_range(0, 3)), $urandom, (i % 2 == 0) ? $urandom : $urandom_range(1, 300),
                  1'b0);
        end

        // Annul in cycle 10 of a DIV: back to IDLE, no ready, results held.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 2'b10;
        bus.opa   = 32'd1000;
        bus.opb   = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        bus.annul = 1'b1;
        @(negedge clk);
        bus.annul = 1'b0;
        #1;
        check("annul_busy", bus.busy, 0);
        check("annul_stall", bus.stallreq, 0);
        repeat (40) @(negedge clk);
        check("annul_ready_cnt", 64'(n_ready), 64'(exp_ready));
        check("annul_hi", bus.result_hi, last.hi);
        check("annul_lo", bus.result_lo, last.lo);

        // Annul together with start in IDLE wins.
        @(negedge clk);
        bus.start = 1'b1;
        bus.annul = 1'b1;
        bus.op    = 2'b01;
        #1;
        check("annul_start_stall", bus.stallreq, 0);
        @(negedge clk);
        bus.start = 1'b0;
        bus.annul = 1'b0;
        #1;
        check("annul_start_busy", bus.busy, 0);

        // Reset in cycle 5 of a MUL.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 2'b01;
        bus.opa   = 32'd9;
        bus.opb   = 32'd9;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("mrst_busy", bus.busy, 0);
        check("mrst_stall", bus.stallreq, 0);
        check("mrst_ready", bus.ready, 0);
        check("mrst_dbz", bus.div_by_zero, 0);
        check("mrst_hi", bus.result_hi, 0);
        check("mrst_lo", bus.result_lo, 0);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("mrst_ready_cnt", 64'(n_ready), 64'(exp_ready));

        do_op(2'b11, 32'd100, 32'd7, 1'b0);
        repeat (3) @(negedge clk);
        check("final_ready_cnt", 64'(n_ready), 64'(exp_ready));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
